// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb
//   Parametrised register file with two combinational read ports, one
//   synchronous write port, optional write-to-read bypass, optional
//   hardwired-zero R0 and a per-register pending (scoreboard) bit used by
//   the controller to stall on read-after-write hazards.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset (clears data and pending)
//   data_in     write data
//   writenum    write address
//   write       write enable
//   readnum_a   read port A address
//   readnum_b   read port B address
//   data_out_a  read port A data (combinational)
//   data_out_b  read port B data (combinational)
//   reserve     mark register reservenum pending
//   reservenum  register to reserve
//   busy_a      readnum_a register pending (combinational)
//   busy_b      readnum_b register pending (combinational)
//   pending     scoreboard vector, registered (not bypassed)
module regfile_2r1w_sb #(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 8,
  parameter int AW      = 3,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  input  logic             reserve,
  input  logic [AW-1:0]    reservenum,
  output logic             busy_a,
  output logic             busy_b,
  output logic [NREGS-1:0] pending
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] wr_dec;
  logic [NREGS-1:0] rsv_dec;
  logic [NREGS-1:0] pend_q;

  // One-hot decodes. Out-of-range addresses match no entry, so they are
  // dropped without any explicit range compare. R0 is excluded when it is
  // hardwired to zero.
  always_comb begin
    wr_dec  = '0;
    rsv_dec = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (ZERO_R0 == 0 || i != 0) begin
        wr_dec[i]  = write   && (writenum   == AW'(i));
        rsv_dec[i] = reserve && (reservenum == AW'(i));
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        regs[g] <= '0;
      end else if (wr_dec[g]) begin
        regs[g] <= data_in;
      end
    end
  end

  // A reserve in the same cycle as a write to the same register wins: the
  // new producer must still be waited for.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (rsv_dec[i]) begin
          pend_q[i] <= 1'b1;
        end else if (wr_dec[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  assign pending = pend_q;

  function automatic logic byp_hit(input logic [AW-1:0] addr);
    return (BYPASS != 0) && write && rst_n && (writenum == addr);
  endfunction

  // hit is set only for an in-range address that is not a hardwired zero.
  function automatic logic [WIDTH-1:0] rd_data(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] v;
    logic             hit;
    v   = '0;
    hit = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (addr == AW'(i)) begin
        hit = 1'b1;
        v   = regs[i];
      end
    end
    if (ZERO_R0 != 0 && addr == '0) hit = 1'b0;
    if (!hit) begin
      v = '0;
    end else if (byp_hit(addr)) begin
      v = data_in;
    end
    return v;
  endfunction

  function automatic logic rd_busy(input logic [AW-1:0] addr);
    logic p;
    p = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (addr == AW'(i)) p = pend_q[i];
    end
    return p && !byp_hit(addr);
  endfunction

  always_comb begin
    data_out_a = rd_data(readnum_a);
    data_out_b = rd_data(readnum_b);
    busy_a     = rd_busy(readnum_a);
    busy_b     = rd_busy(readnum_b);
  end

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
module tb_regfile_2r1w_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum_a, readnum_b;
  logic        reserve;
  logic [2:0]  reservenum;

  // default instance: BYPASS=1, ZERO_R0=0, NREGS=8
  logic [15:0] d_a, d_b;
  logic        d_ba, d_bb;
  logic [7:0]  d_p;
  // BYPASS=0
  logic [15:0] nb_a, nb_b;
  logic        nb_ba, nb_bb;
  logic [7:0]  nb_p;
  // ZERO_R0=1
  logic [15:0] z_a, z_b;
  logic        z_ba, z_bb;
  logic [7:0]  z_p;
  // NREGS=6
  logic [15:0] s_a, s_b;
  logic        s_ba, s_bb;
  logic [5:0]  s_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_2r1w_sb u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .writenum(writenum), .write(write),
    .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(d_a), .data_out_b(d_b),
    .reserve(reserve), .reservenum(reservenum), .busy_a(d_ba), .busy_b(d_bb), .pending(d_p));

  regfile_2r1w_sb #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .writenum(writenum), .write(write),
    .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(nb_a), .data_out_b(nb_b),
    .reserve(reserve), .reservenum(reservenum), .busy_a(nb_ba), .busy_b(nb_bb), .pending(nb_p));

  regfile_2r1w_sb #(.ZERO_R0(1)) u_z (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .writenum(writenum), .write(write),
    .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(z_a), .data_out_b(z_b),
    .reserve(reserve), .reservenum(reservenum), .busy_a(z_ba), .busy_b(z_bb), .pending(z_p));

  regfile_2r1w_sb #(.NREGS(6)) u_n6 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .writenum(writenum), .write(write),
    .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(s_a), .data_out_b(s_b),
    .reserve(reserve), .reservenum(reservenum), .busy_a(s_ba), .busy_b(s_bb), .pending(s_p));

  typedef struct {
    logic        rst_n;
    logic        write;
    logic [2:0]  wn;
    logic [15:0] din;
    logic        rsv;
    logic [2:0]  rn;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] ea;    // default instance expectations (before the edge)
    logic [15:0] eb;
    logic        eba;
    logic        ebb;
    logic [7:0]  ep;
    logic [15:0] nba;   // BYPASS=0 instance port A data / busy
    logic        nbba;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs just after a rising edge; outputs are sampled at the
  // following falling edge, before the next rising edge commits them.
  task automatic drive(input logic r, input logic w, input logic [2:0] wn, input logic [15:0] d,
                       input logic rs, input logic [2:0] rn, input logic [2:0] ra, input logic [2:0] rb);
    @(posedge clk);
    #1;
    rst_n = r; write = w; writenum = wn; data_in = d;
    reserve = rs; reservenum = rn; readnum_a = ra; readnum_b = rb;
    @(negedge clk);
  endtask

  initial begin
    //          rst  wr wn    din       rsv rn    ra    rb     ea        eb        eba   ebb   ep      nba       nbba
    tbl[0]  = '{1'b0,1'b1,3'd3,16'h1111,1'b1,3'd2,3'd3,3'd0, 16'h0000,16'h0000,1'b0,1'b0,8'h00, 16'h0000,1'b0};
    tbl[1]  = '{1'b1,1'b1,3'd3,16'h1234,1'b0,3'd0,3'd0,3'd1, 16'h0000,16'h0000,1'b0,1'b0,8'h00, 16'h0000,1'b0};
    tbl[2]  = '{1'b1,1'b0,3'd0,16'h0000,1'b0,3'd0,3'd3,3'd3, 16'h1234,16'h1234,1'b0,1'b0,8'h00, 16'h1234,1'b0};
    tbl[3]  = '{1'b1,1'b0,3'd0,16'h0000,1'b0,3'd0,3'd3,3'd4, 16'h1234,16'h0000,1'b0,1'b0,8'h00, 16'h1234,1'b0};
    tbl[4]  = '{1'b1,1'b0,3'd0,16'h0000,1'b1,3'd2,3'd2,3'd3, 16'h0000,16'h1234,1'b0,1'b0,8'h00, 16'h0000,1'b0};
    tbl[5]  = '{1'b1,1'b0,3'd0,16'h0000,1'b0,3'd0,3'd2,3'd2, 16'h0000,16'h0000,1'b1,1'b1,8'h04, 16'h0000,1'b1};
    tbl[6]  = '{1'b1,1'b1,3'd2,16'hABCD,1'b0,3'd0,3'd2,3'd2, 16'hABCD,16'hABCD,1'b0,1'b0,8'h04, 16'h0000,1'b1};
    tbl[7]  = '{1'b1,1'b0,3'd0,16'h0000,1'b0,3'd0,3'd2,3'd2, 16'hABCD,16'hABCD,1'b0,1'b0,8'h00, 16'hABCD,1'b0};
    tbl[8]  = '{1'b1,1'b1,3'd2,16'h5A5A,1'b1,3'd2,3'd2,3'd5, 16'h5A5A,16'h0000,1'b0,1'b0,8'h00, 16'hABCD,1'b0};
    tbl[9]  = '{1'b1,1'b0,3'd0,16'h0000,1'b0,3'd0,3'd2,3'd2, 16'h5A5A,16'h5A5A,1'b1,1'b1,8'h04, 16'h5A5A,1'b1};
    tbl[10] = '{1'b1,1'b1,3'd5,16'h00AA,1'b1,3'd6,3'd5,3'd2, 16'h00AA,16'h5A5A,1'b0,1'b1,8'h04, 16'h0000,1'b0};
    tbl[11] = '{1'b1,1'b1,3'd5,16'hBEEF,1'b0,3'd0,3'd5,3'd6, 16'hBEEF,16'h0000,1'b0,1'b1,8'h44, 16'h00AA,1'b0};
    tbl[12] = '{1'b1,1'b0,3'd0,16'h0000,1'b0,3'd0,3'd5,3'd6, 16'hBEEF,16'h0000,1'b0,1'b1,8'h44, 16'hBEEF,1'b0};

    rst_n = 1'b0; write = 1'b0; writenum = '0; data_in = '0;
    reserve = 1'b0; reservenum = '0; readnum_a = '0; readnum_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_data_a", {16'h0, d_a}, 32'h0);
    chk("reset_pending", {24'h0, d_p}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst_n, tbl[i].write, tbl[i].wn, tbl[i].din,
            tbl[i].rsv, tbl[i].rn, tbl[i].ra, tbl[i].rb);
      chk($sformatf("v%0d_data_a", i), {16'h0, d_a}, {16'h0, tbl[i].ea});
      chk($sformatf("v%0d_data_b", i), {16'h0, d_b}, {16'h0, tbl[i].eb});
      chk($sformatf("v%0d_busy_a", i), {31'h0, d_ba}, {31'h0, tbl[i].eba});
      chk($sformatf("v%0d_busy_b", i), {31'h0, d_bb}, {31'h0, tbl[i].ebb});
      chk($sformatf("v%0d_pending", i), {24'h0, d_p}, {24'h0, tbl[i].ep});
      chk($sformatf("v%0d_nobyp_a", i), {16'h0, nb_a}, {16'h0, tbl[i].nba});
      chk($sformatf("v%0d_nobyp_busy_a", i), {31'h0, nb_ba}, {31'h0, tbl[i].nbba});
    end

    // Hardwired R0: write and reserve of R0 have no effect.
    drive(1'b1, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0, 3'd0);
    chk("z_r0_bypass_blocked", {16'h0, z_a}, 32'h0);
    chk("z_r0_busy", {31'h0, z_ba}, 32'h0);
    chk("dflt_r0_bypass", {16'h0, d_a}, 32'h0000FFFF);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0);
    chk("z_r0_data", {16'h0, z_a}, 32'h0);
    chk("z_r0_pending", {31'h0, z_p[0]}, 32'h0);
    chk("z_r0_busy_after", {31'h0, z_ba}, 32'h0);
    chk("dflt_r0_data", {16'h0, d_a}, 32'h0000FFFF);
    chk("dflt_r0_wr_rsv_pending", {31'h0, d_p[0]}, 32'h1);

    // NREGS=6: addresses 6 and 7 are out of range for write, reserve, read.
    drive(1'b1, 1'b1, 3'd7, 16'h5555, 1'b1, 3'd6, 3'd6, 3'd7);
    chk("n6_oor_a", {16'h0, s_a}, 32'h0);
    chk("n6_oor_b", {16'h0, s_b}, 32'h0);
    chk("n6_oor_busy_a", {31'h0, s_ba}, 32'h0);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd5);
    chk("n6_pending", {26'h0, s_p}, 32'h00000005);
    chk("n6_r3", {16'h0, s_a}, 32'h00001234);
    chk("n6_r5", {16'h0, s_b}, 32'h0000BEEF);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd6, 3'd7);
    chk("n6_rd6", {16'h0, s_a}, 32'h0);
    chk("n6_rd7", {16'h0, s_b}, 32'h0);

    // Mid-operation reset discards the concurrent write.
    drive(1'b1, 1'b1, 3'd1, 16'h0F0F, 1'b1, 3'd4, 3'd1, 3'd4);
    chk("mr_bypass", {16'h0, d_a}, 32'h00000F0F);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd1, 3'd4);
    chk("mr_r1", {16'h0, d_a}, 32'h00000F0F);
    chk("mr_busy_r4", {31'h0, d_bb}, 32'h1);
    chk("mr_pend_r4", {31'h0, d_p[4]}, 32'h1);
    drive(1'b0, 1'b1, 3'd1, 16'h7777, 1'b0, 3'd0, 3'd1, 3'd4);
    chk("mr_no_bypass_in_reset", {16'h0, d_a}, 32'h00000F0F);
    chk("mr_busy_in_reset", {31'h0, d_bb}, 32'h1);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd1, 3'd4);
    chk("mr_r1_cleared", {16'h0, d_a}, 32'h0);
    chk("mr_busy_cleared", {31'h0, d_bb}, 32'h0);
    chk("mr_pend_dflt", {24'h0, d_p}, 32'h0);
    chk("mr_pend_nb", {24'h0, nb_p}, 32'h0);
    chk("mr_pend_z", {24'h0, z_p}, 32'h0);
    chk("mr_pend_n6", {26'h0, s_p}, 32'h0);
    chk("mr_nb_r1_cleared", {16'h0, nb_a}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
